reg_access_ctrl: RTL and testbench

- Upstream bus master for the configuration register block. It sits between the host/CPU-side command interface and the register block's sel_en/wr_rd_s/addr/wr_data/ack/rd_data access bus.
- Accepts one host request at a time on a valid/ready handshake and runs one bus access.
- Waits for ack, or aborts on timeout, then returns read data and error status on a valid/ready response channel.
- Keeps a saturating count of timed-out accesses for debug.

---
 rtl/reg_access_ctrl_if.sv | 41 ++++
 rtl/reg_access_ctrl.sv | 100 ++++++++++
 tb/tb_reg_access_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_if.sv
// Host command/response channel plus register-block access bus of reg_access_ctrl.
//   host side : req_valid/req_ready/req_wr/req_addr/req_wdata,
//               resp_valid/resp_ready/resp_rdata/resp_err
//   bus side  : sel_en/wr_rd_s/addr/wr_data/rd_data/ack
//   debug     : timeout_cnt (8-bit saturating count of timed-out accesses)
// Modport master is the controller; modport slave is the host plus register block.
interface reg_access_ctrl_if #(
   parameter int NUM_OF_PORTS = 4,
   parameter int W_WIDTH      = 8
);
   localparam int AW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;

   logic               req_valid;
   logic               req_ready;
   logic               req_wr;
   logic [AW-1:0]      req_addr;
   logic [W_WIDTH-1:0] req_wdata;
   logic               resp_valid;
   logic               resp_ready;
   logic [W_WIDTH-1:0] resp_rdata;
   logic               resp_err;
   logic               sel_en;
   logic               wr_rd_s;
   logic [AW-1:0]      addr;
   logic [W_WIDTH-1:0] wr_data;
   logic [W_WIDTH-1:0] rd_data;
   logic               ack;
   logic [7:0]         timeout_cnt;

   modport master (
      input  req_valid, req_wr, req_addr, req_wdata, resp_ready, rd_data, ack,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output sel_en, wr_rd_s, addr, wr_data, timeout_cnt
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wdata, resp_ready, rd_data, ack,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  sel_en, wr_rd_s, addr, wr_data, timeout_cnt
   );
endinterface

// File: rtl/reg_access_ctrl.sv
// Bus master for the configuration register block. Takes one host request at a
// time, runs a single sel_en access, waits for ack or times out, and returns
// read data / error status on the response channel.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_access_ctrl_if.master (host request/response, register bus,
//          timeout_cnt debug counter)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | req_ready high, waiting for req_valid
// S_ACCESS | sel_en high, bus fields frozen, waiting for ack or timeout
// S_RESP   | resp_valid high, response held until resp_ready
module reg_access_ctrl #(
   parameter int NUM_OF_PORTS   = 4,
   parameter int W_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   reg_access_ctrl_if.master  bus
);
   localparam int AW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      wait_cnt;
   logic               wr_rd_s_q;
   logic [AW-1:0]      addr_q;
   logic [W_WIDTH-1:0] wr_data_q;
   logic [W_WIDTH-1:0] resp_rdata_q;
   logic               resp_err_q;
   logic [7:0]         timeout_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         wr_rd_s_q     <= 1'b0;
         addr_q        <= '0;
         wr_data_q     <= '0;
         resp_rdata_q  <= '0;
         resp_err_q    <= 1'b0;
         timeout_cnt_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  wr_rd_s_q <= bus.req_wr;
                  addr_q    <= bus.req_addr;
                  wr_data_q <= bus.req_wdata;
                  wait_cnt  <= '0;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               wait_cnt <= wait_cnt + 1'b1;
               // ack is checked first so a same-cycle ack beats the timeout
               if (bus.ack) begin
                  resp_rdata_q <= wr_rd_s_q ? '0 : bus.rd_data;
                  resp_err_q   <= 1'b0;
                  state        <= S_RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b1;
                  if (timeout_cnt_q != 8'hFF) begin
                     timeout_cnt_q <= timeout_cnt_q + 8'd1;
                  end
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake and select lines decode straight from the state register, so
   // an asynchronous reset drops sel_en without waiting for a clock edge.
   assign bus.req_ready   = (state == S_IDLE);
   assign bus.sel_en      = (state == S_ACCESS);
   assign bus.resp_valid  = (state == S_RESP);
   assign bus.wr_rd_s     = wr_rd_s_q;
   assign bus.addr        = addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
module tb_reg_access_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   reg_access_ctrl_if #(.NUM_OF_PORTS(4), .W_WIDTH(8)) bus_if ();

   reg_access_ctrl #(
      .NUM_OF_PORTS  (4),
      .W_WIDTH       (8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [1:0] addr;
      logic [7:0] wdata;
      int         ack_dly;    // sel_en cycle carrying ack, 0 = never
      logic [7:0] rd;
      int         rdy_dly;    // cycles resp_ready held low in RESP
      bit         late_ack;   // pulse ack on the 2nd RESP cycle
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_sel;
      logic [7:0] exp_tcnt;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input vec_t v);
      int n_sel;
      bus_if.req_valid = 1'b1;
      bus_if.req_wr    = v.wr;
      bus_if.req_addr  = v.addr;
      bus_if.req_wdata = v.wdata;
      step();
      bus_if.req_valid = 1'b0;
      n_sel = 0;
      while (bus_if.sel_en === 1'b1 && n_sel < 40) begin
         n_sel++;
         check("bus_dir", 32'(bus_if.wr_rd_s), 32'(v.wr));
         check("bus_addr", 32'(bus_if.addr), 32'(v.addr));
         check("bus_wdata", 32'(bus_if.wr_data), 32'(v.wdata));
         check("busy_ready", 32'(bus_if.req_ready), 32'd0);
         if (n_sel == v.ack_dly) begin
            bus_if.ack     = 1'b1;
            bus_if.rd_data = v.rd;
         end else begin
            bus_if.ack     = 1'b0;
            bus_if.rd_data = 8'hEE;
         end
         step();
      end
      bus_if.ack     = 1'b0;
      bus_if.rd_data = 8'h00;
      check("sel_cycles", 32'(n_sel), 32'(v.exp_sel));
      check("resp_valid", 32'(bus_if.resp_valid), 32'd1);
      check("resp_rdata", 32'(bus_if.resp_rdata), 32'(v.exp_rdata));
      check("resp_err", 32'(bus_if.resp_err), 32'(v.exp_err));
      check("timeout_cnt", 32'(bus_if.timeout_cnt), 32'(v.exp_tcnt));
      for (int i = 0; i < v.rdy_dly; i++) begin
         check("hold_valid", 32'(bus_if.resp_valid), 32'd1);
         check("hold_rdata", 32'(bus_if.resp_rdata), 32'(v.exp_rdata));
         check("hold_ready", 32'(bus_if.req_ready), 32'd0);
         check("hold_sel", 32'(bus_if.sel_en), 32'd0);
         if (v.late_ack && i == 1) begin
            bus_if.ack     = 1'b1;
            bus_if.rd_data = 8'h99;
         end else begin
            bus_if.ack     = 1'b0;
            bus_if.rd_data = 8'h00;
         end
         step();
      end
      bus_if.ack = 1'b0;
      if (v.rdy_dly > 0) begin
         check("post_hold_rdata", 32'(bus_if.resp_rdata), 32'(v.exp_rdata));
         check("post_hold_err", 32'(bus_if.resp_err), 32'(v.exp_err));
         check("post_hold_tcnt", 32'(bus_if.timeout_cnt), 32'(v.exp_tcnt));
      end
      bus_if.resp_ready = 1'b1;
      step();
      bus_if.resp_ready = 1'b0;
      check("done_valid", 32'(bus_if.resp_valid), 32'd0);
      check("done_ready", 32'(bus_if.req_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   gap;
      vec_t v;
      n_checks = 0;
      n_errors = 0;

      //          wr    addr   wdata  ack rd     rdy late exp_rd exp_err sel tcnt
      vecs[0] = '{1'b1, 2'd2, 8'hA5,  1, 8'h77,  0, 0, 8'h00, 1'b0,  1, 8'd0};
      vecs[1] = '{1'b0, 2'd1, 8'h00,  3, 8'h3C,  0, 0, 8'h3C, 1'b0,  3, 8'd0};
      vecs[2] = '{1'b0, 2'd3, 8'h12,  0, 8'h55,  4, 1, 8'h00, 1'b1, 16, 8'd1};
      vecs[3] = '{1'b0, 2'd0, 8'h00, 16, 8'hC3,  1, 0, 8'hC3, 1'b0, 16, 8'd1};
      vecs[4] = '{1'b0, 2'd2, 8'h00,  2, 8'h5A,  5, 0, 8'h5A, 1'b0,  2, 8'd1};
      vecs[5] = '{1'b1, 2'd1, 8'h0F,  0, 8'h00,  0, 0, 8'h00, 1'b1, 16, 8'd2};
      vecs[6] = '{1'b1, 2'd0, 8'hFF,  4, 8'h81,  2, 0, 8'h00, 1'b0,  4, 8'd2};
      vecs[7] = '{1'b0, 2'd3, 8'h00, 15, 8'h7E,  0, 0, 8'h7E, 1'b0, 15, 8'd2};

      bus_if.req_valid  = 1'b0;
      bus_if.req_wr     = 1'b0;
      bus_if.req_addr   = 2'd0;
      bus_if.req_wdata  = 8'h00;
      bus_if.resp_ready = 1'b0;
      bus_if.rd_data    = 8'h00;
      bus_if.ack        = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_sel", 32'(bus_if.sel_en), 32'd0);
      check("rst_ready", 32'(bus_if.req_ready), 32'd1);
      check("rst_valid", 32'(bus_if.resp_valid), 32'd0);
      check("rst_tcnt", 32'(bus_if.timeout_cnt), 32'd0);
      check("rst_rdata", 32'(bus_if.resp_rdata), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) do_txn(vecs[i]);

      // back-to-back: second request waits behind a stalled response
      bus_if.req_valid = 1'b1;
      bus_if.req_wr    = 1'b0;
      bus_if.req_addr  = 2'd1;
      bus_if.req_wdata = 8'h00;
      step();
      bus_if.req_wr    = 1'b1;
      bus_if.req_addr  = 2'd3;
      bus_if.req_wdata = 8'h42;
      check("b2b_sel_a", 32'(bus_if.sel_en), 32'd1);
      check("b2b_addr_a", 32'(bus_if.addr), 32'd1);
      bus_if.ack     = 1'b1;
      bus_if.rd_data = 8'h11;
      step();
      bus_if.ack = 1'b0;
      gap = 0;
      for (int i = 0; i < 5; i++) begin
         check("b2b_hold_valid", 32'(bus_if.resp_valid), 32'd1);
         check("b2b_hold_rdata", 32'(bus_if.resp_rdata), 32'h11);
         check("b2b_hold_ready", 32'(bus_if.req_ready), 32'd0);
         if (bus_if.sel_en === 1'b0) gap++;
         step();
      end
      if (bus_if.sel_en === 1'b0) gap++;
      bus_if.resp_ready = 1'b1;
      step();
      bus_if.resp_ready = 1'b0;
      check("b2b_idle_ready", 32'(bus_if.req_ready), 32'd1);
      if (bus_if.sel_en === 1'b0) gap++;
      step();
      bus_if.req_valid = 1'b0;
      check("b2b_gap", 32'(gap), 32'd7);
      check("b2b_sel_b", 32'(bus_if.sel_en), 32'd1);
      check("b2b_addr_b", 32'(bus_if.addr), 32'd3);
      check("b2b_dir_b", 32'(bus_if.wr_rd_s), 32'd1);
      check("b2b_wdata_b", 32'(bus_if.wr_data), 32'h42);
      bus_if.ack = 1'b1;
      step();
      bus_if.ack = 1'b0;
      check("b2b_rdata_b", 32'(bus_if.resp_rdata), 32'd0);
      check("b2b_err_b", 32'(bus_if.resp_err), 32'd0);
      bus_if.resp_ready = 1'b1;
      step();
      bus_if.resp_ready = 1'b0;

      // drive timeout_cnt into saturation
      for (int i = 0; i < 254; i++) begin
         v = '{1'b0, 2'd0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1'b1, 16,
               (3 + i > 255) ? 8'd255 : 8'(3 + i)};
         do_txn(v);
      end
      check("tcnt_saturated", 32'(bus_if.timeout_cnt), 32'd255);

      // reset in the middle of an access
      bus_if.req_valid = 1'b1;
      bus_if.req_wr    = 1'b1;
      bus_if.req_addr  = 2'd2;
      bus_if.req_wdata = 8'h66;
      step();
      bus_if.req_valid = 1'b0;
      step();
      step();
      check("pre_rst_sel", 32'(bus_if.sel_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sel", 32'(bus_if.sel_en), 32'd0);
      check("mid_rst_valid", 32'(bus_if.resp_valid), 32'd0);
      check("mid_rst_ready", 32'(bus_if.req_ready), 32'd1);
      check("mid_rst_tcnt", 32'(bus_if.timeout_cnt), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_valid", 32'(bus_if.resp_valid), 32'd0);
         check("post_rst_sel", 32'(bus_if.sel_en), 32'd0);
      end
      v = '{1'b0, 2'd1, 8'h00, 1, 8'hB4, 0, 0, 8'hB4, 1'b0, 1, 8'd0};
      do_txn(v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
